// File: rtl/relu_pkg.sv
// Shared definitions for the ReLU forward/backward blocks.
package relu_pkg;

   // Default activation/gradient word width.
   localparam int RELU_DATA_W = 18;

   // All-zero word driven by a blocked gradient.
   localparam logic [RELU_DATA_W-1:0] RELU_ZERO_WORD = '0;

endpackage

// File: rtl/relu_backward_mask_fifo.sv
// One-bit-wide FIFO that remembers the ReLU mask of each forward sample
// until the matching gradient arrives.
module mask_fifo
   import relu_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   din,
   input  logic                   pop,
   output logic                   dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !clear && !rst;
   assign do_pop  = pop && !empty && !clear && !rst;
   assign dout    = mem[rd_ptr];

   // Mask storage: contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy: a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/relu_backward.sv
// ReLU backward pass: gradients are passed through where the forward
// pre-activation was non-negative and zeroed elsewhere. Forward masks are
// buffered in order and consumed one per accepted gradient.
module relu_backward
   import relu_pkg::*;
#(
   parameter int DATA_W = RELU_DATA_W,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     fwd_valid,
   input  logic [DATA_W-1:0]        fwd_val,
   output logic                     fwd_ready,
   input  logic                     grad_in_valid,
   input  logic signed [DATA_W-1:0] grad_in,
   output logic                     grad_in_ready,
   output logic                     grad_out_valid,
   output logic signed [DATA_W-1:0] grad_out,
   input  logic                     grad_out_ready,
   output logic [$clog2(DEPTH):0]   mask_count,
   output logic                     underflow_err
);

   // Pass the gradient when the mask is set, otherwise emit zero.
   function automatic logic signed [DATA_W-1:0] gate_grad(
      input logic signed [DATA_W-1:0] g,
      input logic                     m
   );
      return m ? g : $signed(DATA_W'(RELU_ZERO_WORD));
   endfunction

   logic                     fwd_mask;
   logic                     push;
   logic                     pop;
   logic                     mask_head;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic signed [DATA_W-1:0] gated_p0;
   logic signed [DATA_W-1:0] grad_p1;
   logic                     vld_p1;
   logic                     err_q;
   logic                     unused_fwd_bits;

   // Only the sign of the pre-activation matters; zero counts as pass-through.
   assign unused_fwd_bits = ^fwd_val[DATA_W-2:0];
   assign fwd_mask        = ~fwd_val[DATA_W-1];

   // Readiness uses registered state only, so a pop never frees room for a
   // push in the same cycle and an empty buffer never bypasses.
   assign fwd_ready     = !fifo_full && !clear && !rst;
   assign grad_in_ready = !fifo_empty && (!vld_p1 || grad_out_ready) && !clear && !rst;
   assign push          = fwd_valid && fwd_ready;
   assign pop           = grad_in_valid && grad_in_ready;

   mask_fifo #(
      .DEPTH (DEPTH)
   ) u_mask_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (push),
      .din   (fwd_mask),
      .pop   (pop),
      .dout  (mask_head),
      .count (mask_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // ---- p0: gate accepted gradient with the oldest mask ----
   assign gated_p0 = gate_grad(grad_in, mask_head);

   // ---- p1: output register, held while downstream stalls ----
   // Output stage: load on accept, drop valid on a handshake with no new word.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         vld_p1  <= 1'b0;
         grad_p1 <= '0;
      end else if (pop) begin
         vld_p1  <= 1'b1;
         grad_p1 <= gated_p0;
      end else if (grad_out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   // Sticky flag for gradients offered while no mask is stored.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         err_q <= 1'b0;
      end else if (grad_in_valid && fifo_empty) begin
         err_q <= 1'b1;
      end
   end

   assign grad_out_valid = vld_p1;
   assign grad_out       = grad_p1;
   assign underflow_err  = err_q;

endmodule

// File: tb/tb_relu_backward.sv
// Testbench for relu_backward: directed vectors, corner-case sequences and
// a randomized run against a queue-based reference model.
module tb_relu_backward;

   localparam int DW    = 18;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic          fwd_valid = 1'b0;
   logic [DW-1:0] fwd_val = '0;
   logic          fwd_ready;
   logic          grad_in_valid = 1'b0;
   logic [DW-1:0] grad_in = '0;
   logic          grad_in_ready;
   logic          grad_out_valid;
   logic [DW-1:0] grad_out;
   logic          grad_out_ready = 1'b1;
   logic [CW-1:0] mask_count;
   logic          underflow_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [DW-1:0] fwd;
      logic [DW-1:0] grad;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs[4];

   // Reference model state
   bit            mq[$];
   bit            ev;
   logic [DW-1:0] ed;
   bit            eerr;

   relu_backward #(
      .DATA_W (DW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .clear          (clear),
      .fwd_valid      (fwd_valid),
      .fwd_val        (fwd_val),
      .fwd_ready      (fwd_ready),
      .grad_in_valid  (grad_in_valid),
      .grad_in        (grad_in),
      .grad_in_ready  (grad_in_ready),
      .grad_out_valid (grad_out_valid),
      .grad_out       (grad_out),
      .grad_out_ready (grad_out_ready),
      .mask_count     (mask_count),
      .underflow_err  (underflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      fwd_valid = 1'b0;
      grad_in_valid = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mq.delete();
      ev = 1'b0;
      eerr = 1'b0;
   endtask

   initial begin
      bit            m;
      logic [DW-1:0] e;
      bit            efr, egr, psh, pp;

      // ---------------- reset ----------------
      repeat (2) @(posedge clk);
      #1;
      check("fwd_ready_in_reset", 32'(fwd_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_count", 32'(mask_count), 32'd0);
      check("rst_valid", 32'(grad_out_valid), 32'd0);
      check("rst_data", 32'(grad_out), 32'd0);
      check("rst_err", 32'(underflow_err), 32'd0);
      check("rst_gready", 32'(grad_in_ready), 32'd0);
      check("rst_fready", 32'(fwd_ready), 32'd1);

      // ---------------- basic gating vectors ----------------
      vecs[0] = '{18'd5,       18'd100, 18'd100};
      vecs[1] = '{18'h3FFFD,   18'd200, 18'd0};
      vecs[2] = '{18'd0,       18'd300, 18'd300};
      vecs[3] = '{18'h3FFFF,   18'd400, 18'd0};
      for (int i = 0; i < 4; i++) begin
         fwd_valid = 1'b1;
         fwd_val = vecs[i].fwd;
         tick();
      end
      fwd_valid = 1'b0;
      check("vec_count", 32'(mask_count), 32'd4);
      grad_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         grad_in_valid = 1'b1;
         grad_in = vecs[i].grad;
         tick();
         check($sformatf("vec%0d_valid", i), 32'(grad_out_valid), 32'd1);
         check($sformatf("vec%0d_data", i), 32'(grad_out), 32'(vecs[i].exp));
      end
      grad_in_valid = 1'b0;
      tick();
      check("vec_valid_drop", 32'(grad_out_valid), 32'd0);
      check("vec_count_end", 32'(mask_count), 32'd0);

      // ---------------- full buffer ----------------
      for (int i = 0; i < DEPTH; i++) begin
         fwd_valid = 1'b1;
         fwd_val = DW'(i + 1);
         tick();
      end
      check("full_count", 32'(mask_count), 32'd16);
      check("full_fready", 32'(fwd_ready), 32'd0);
      tick();
      check("full_17th_rejected", 32'(mask_count), 32'd16);
      grad_in_valid = 1'b1;
      grad_in = 18'd7;
      tick();
      check("full_pop_count", 32'(mask_count), 32'd15);
      check("full_fready_after_pop", 32'(fwd_ready), 32'd1);
      check("full_pop_data", 32'(grad_out), 32'd7);
      do_clear();
      check("clear_count", 32'(mask_count), 32'd0);
      check("clear_valid", 32'(grad_out_valid), 32'd0);

      // ---------------- output stall ----------------
      fwd_valid = 1'b1;
      fwd_val = 18'd9;
      tick();
      tick();
      fwd_valid = 1'b0;
      grad_out_ready = 1'b0;
      grad_in_valid = 1'b1;
      grad_in = 18'h1FFFF;
      tick();
      grad_in = 18'd5;
      for (int i = 0; i < 3; i++) begin
         check("stall_gready", 32'(grad_in_ready), 32'd0);
         tick();
         check("stall_valid", 32'(grad_out_valid), 32'd1);
         check("stall_data", 32'(grad_out), 32'h1FFFF);
         check("stall_count", 32'(mask_count), 32'd1);
      end
      grad_out_ready = 1'b1;
      #1;
      check("stall_release_gready", 32'(grad_in_ready), 32'd1);
      tick();
      check("stall_next_data", 32'(grad_out), 32'd5);
      grad_in_valid = 1'b0;
      tick();
      check("stall_drain_valid", 32'(grad_out_valid), 32'd0);

      // ---------------- underflow ----------------
      grad_in_valid = 1'b1;
      grad_in = 18'd11;
      #1;
      check("uf_gready", 32'(grad_in_ready), 32'd0);
      tick();
      check("uf_set", 32'(underflow_err), 32'd1);
      check("uf_no_output", 32'(grad_out_valid), 32'd0);
      grad_in_valid = 1'b0;
      tick();
      tick();
      check("uf_sticky", 32'(underflow_err), 32'd1);
      do_clear();
      check("uf_cleared", 32'(underflow_err), 32'd0);

      // ---------------- steady push+pop with wrap ----------------
      for (int i = 0; i < 8; i++) begin
         fwd_valid = 1'b1;
         fwd_val = DW'($urandom());
         mq.push_back(~fwd_val[DW-1]);
         tick();
      end
      check("wrap_fill", 32'(mask_count), 32'd8);
      grad_out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         fwd_valid = 1'b1;
         fwd_val = DW'($urandom());
         grad_in_valid = 1'b1;
         grad_in = DW'($urandom());
         m = mq.pop_front();
         e = m ? grad_in : '0;
         mq.push_back(~fwd_val[DW-1]);
         tick();
         check("wrap_count", 32'(mask_count), 32'd8);
         check("wrap_data", 32'(grad_out), 32'(e));
      end
      fwd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         grad_in = DW'($urandom());
         m = mq.pop_front();
         e = m ? grad_in : '0;
         tick();
         check("wrap_drain", 32'(grad_out), 32'(e));
      end
      grad_in_valid = 1'b0;
      tick();
      check("wrap_empty", 32'(mask_count), 32'd0);

      // ---------------- reset mid-transfer ----------------
      for (int i = 0; i < 6; i++) begin
         fwd_valid = 1'b1;
         fwd_val = DW'(i);
         tick();
      end
      fwd_valid = 1'b0;
      grad_out_ready = 1'b0;
      grad_in_valid = 1'b1;
      grad_in = 18'h123;
      tick();
      grad_in_valid = 1'b0;
      check("midrst_pre_count", 32'(mask_count), 32'd5);
      check("midrst_pre_valid", 32'(grad_out_valid), 32'd1);
      rst = 1'b1;
      tick();
      check("midrst_count", 32'(mask_count), 32'd0);
      check("midrst_valid", 32'(grad_out_valid), 32'd0);
      check("midrst_data", 32'(grad_out), 32'd0);
      check("midrst_fready", 32'(fwd_ready), 32'd0);
      rst = 1'b0;
      grad_out_ready = 1'b1;
      #1;
      check("midrst_release_fready", 32'(fwd_ready), 32'd1);

      // ---------------- randomized run against the model ----------------
      do_clear();
      for (int cyc = 0; cyc < 600; cyc++) begin
         clear = ($urandom_range(0, 59) == 0);
         fwd_valid = ($urandom_range(0, 2) != 0);
         fwd_val = DW'($urandom());
         grad_in_valid = ($urandom_range(0, 3) < 2);
         grad_in = DW'($urandom());
         grad_out_ready = ($urandom_range(0, 3) != 0);
         #1;
         efr = !clear && (mq.size() < DEPTH);
         egr = !clear && (mq.size() > 0) && (!ev || grad_out_ready);
         check("rnd_fready", 32'(fwd_ready), 32'(efr));
         check("rnd_gready", 32'(grad_in_ready), 32'(egr));
         psh = fwd_valid && efr;
         pp = grad_in_valid && egr;
         if (clear) begin
            mq.delete();
            ev = 1'b0;
            eerr = 1'b0;
         end else begin
            if (grad_in_valid && mq.size() == 0) eerr = 1'b1;
            if (pp) begin
               m = mq.pop_front();
               ev = 1'b1;
               ed = m ? grad_in : '0;
            end else if (grad_out_ready) begin
               ev = 1'b0;
            end
            if (psh) mq.push_back(~fwd_val[DW-1]);
         end
         tick();
         check("rnd_count", 32'(mask_count), 32'(mq.size()));
         check("rnd_valid", 32'(grad_out_valid), 32'(ev));
         check("rnd_err", 32'(underflow_err), 32'(eerr));
         if (ev) check("rnd_data", 32'(grad_out), 32'(ed));
      end
      clear = 1'b0;
      fwd_valid = 1'b0;
      grad_in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/relu_backward.md
RELU_BACKWARD -- requirements
Module: relu_backward

Interface
REQ-001 Parameter DATA_W, default 18, width of activation and gradient words in two's complement.
REQ-002 Parameter DEPTH, default 16, mask buffer entries; power of two, 2..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 clear  input  1  synchronous flush of mask buffer and output stage.
REQ-006 fwd_valid  input  1  forward pre-activation word present.
REQ-007 fwd_val  input  DATA_W  forward pre-activation value; only bit DATA_W-1 used.
REQ-008 fwd_ready  output  1  mask buffer can accept a forward sample.
REQ-009 grad_in_valid  input  1  upstream gradient word present.
REQ-010 grad_in  input  DATA_W  upstream gradient dL/dy.
REQ-011 grad_in_ready  output  1  block accepts grad_in this cycle.
REQ-012 grad_out_valid  output  1  gated gradient word present.
REQ-013 grad_out  output  DATA_W  gated gradient dL/dx.
REQ-014 grad_out_ready  input  1  downstream accepts grad_out.
REQ-015 mask_count  output  $clog2(DEPTH)+1  stored mask entries.
REQ-016 underflow_err  output  1  sticky: grad_in_valid held while buffer empty for 1 cycle.

Function
REQ-017 Forward accept when fwd_valid && fwd_ready; push mask bit m = ~fwd_val[DATA_W-1], x>=0 gives m=1, consistent with forward ReLU pass-through at zero.
REQ-018 fwd_ready = (mask_count < DEPTH) && !clear.
REQ-019 Mask buffer is FIFO; gradients pair with masks in forward-capture order.
REQ-020 Gradient accept when grad_in_valid && grad_in_ready; pop one mask bit in same cycle.
REQ-021 grad_in_ready = (mask_count > 0) && (!grad_out_valid || grad_out_ready) && !clear.
REQ-022 On accept, the registered output stage loads grad_out = m ? grad_in : 0 and sets grad_out_valid next cycle; latency exactly 1 cycle.
REQ-023 grad_out_valid clears on handshake without new accept; grad_out and grad_out_valid hold stable while grad_out_valid && !grad_out_ready.
REQ-024 Simultaneous push and pop: mask_count unchanged; an empty buffer does not bypass, so the pop waits for the next cycle.
REQ-025 Full buffer: no push occurs; a pop in the same cycle does not enable the push, because fwd_ready depends on the registered count only.
REQ-026 Read/write pointers wrap modulo DEPTH; mask_count saturates at DEPTH and never goes negative.
REQ-027 Gradients are gated by the mask only; no arithmetic on values, so width is preserved and no overflow is possible.
REQ-028 underflow_err sets when grad_in_valid=1 and mask_count=0 and clear=0; it clears only on rst or clear.
REQ-029 clear: pointers, mask_count, grad_out_valid and underflow_err go to 0 next cycle, and no push or pop occurs in that cycle.

Reset
REQ-030 rst=1: fwd_ready=0 during reset; after release mask_count=0, grad_out_valid=0, grad_out=0, underflow_err=0, grad_in_ready=0, fwd_ready=1.
REQ-031 Reset mid-transfer discards stored masks and any pending output word; no partial word is emitted.
REQ-032 Mask storage contents need no reset; only pointers and count.

Structure
REQ-033 Shared package relu_pkg holds DATA_W default (18) and the zero-word constant, shared with relu_activation.
REQ-034 One sub-module mask_fifo (1-bit wide, DEPTH deep, push/pop/count/full/empty) holds the mask buffer; gating and output register stay in relu_backward.

Verification
REQ-035 Push fwd 5, -3, 0, -1 (18-bit), then grads 100, 200, 300, 400 -> grad_out 100, 0, 300, 0, each 1 cycle after accept.
REQ-036 Push 16 positives -> fwd_ready=0 and mask_count=16; the 17th fwd_valid is not accepted; one gradient pop -> fwd_ready=1 the next cycle.
REQ-037 grad_out_ready=0 for 3 cycles with grad_out=0x1FFFF valid -> value held; grad_in_ready=0 during stall.
REQ-038 grad_in_valid with empty buffer -> grad_in_ready=0 and underflow_err=1 next cycle, sticky until clear.
REQ-039 Buffer at count 8, simultaneous push and pop for 20 cycles -> count stays 8 and pointers wrap with order preserved.
REQ-040 rst asserted with count 5 and grad_out_valid=1 -> next cycle count=0, grad_out_valid=0, grad_out=0.
